// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the two-port memory arbiter.
//   ST_*   : sequencer state encodings (IDLE -> ACCESS -> ACK -> IDLE).
//   GNT_R* : grant index for requester 0 / requester 1.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic GNT_R0 = 1'b0;
    localparam logic GNT_R1 = 1'b1;

endpackage

// File: rtl/mem_rr_arb2.sv
// mem_rr_arb2: combinational two-way round-robin pick.
//   req_i[1:0]    : request lines, bit n = requester n.
//   last_grant_i  : index of the requester granted most recently.
//   gnt_o[1:0]    : one-hot grant (all zero when nothing requests).
module mem_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        // On a tie the requester that did not win last time goes first.
        if (req_i == 2'b11)
            gnt_o = (last_grant_i == GNT_R1) ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer in front of a single-port memory.
//   clk, rst_n               : clock (rising edge), async active-low reset.
//   rN_req/wr/addr/wdata     : requester N operation, held until rN_ack.
//   rN_ack, rN_rdata         : one-cycle completion pulse and read data.
//   mem_wr, mem_rd, mem_addr : registered memory control.
//   mem_data                 : shared bus, driven only while mem_wr is high.
// Each transaction takes IDLE (grant) -> ACCESS (one memory cycle) -> ACK.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [AWIDTH-1:0] r0_addr,
    input  logic [DWIDTH-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DWIDTH-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [AWIDTH-1:0] r1_addr,
    input  logic [DWIDTH-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DWIDTH-1:0] r1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    logic [1:0]        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q, gnt_d;
    logic              op_wr_q, op_wr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DWIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]        arb_gnt;

    mem_rr_arb2 u_arb (
        .req_i       ({r1_req, r0_req}),
        .last_grant_i(last_gnt_q),
        .gnt_o       (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        op_wr_d    = op_wr_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        mem_wr_d   = 1'b0;
        mem_rd_d   = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    // Latch the winner's operands so later input changes are ignored.
                    gnt_d      = arb_gnt[1] ? GNT_R1 : GNT_R0;
                    last_gnt_d = gnt_d;
                    op_wr_d    = arb_gnt[1] ? r1_wr    : r0_wr;
                    mem_addr_d = arb_gnt[1] ? r1_addr  : r0_addr;
                    wdata_d    = arb_gnt[1] ? r1_wdata : r0_wdata;
                    mem_wr_d   = op_wr_d;
                    mem_rd_d   = ~op_wr_d;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (gnt_q == GNT_R0) begin
                    ack0_d = 1'b1;
                    if (!op_wr_q) rdata0_d = mem_data;
                end else begin
                    ack1_d = 1'b1;
                    if (!op_wr_q) rdata1_d = mem_data;
                end
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= GNT_R1;
            gnt_q      <= GNT_R0;
            op_wr_q    <= 1'b0;
            wdata_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            op_wr_q    <= op_wr_d;
            wdata_q    <= wdata_d;
            mem_wr_q   <= mem_wr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    // The bus enable follows the registered write strobe, so it can never
    // overlap a read cycle.
    assign mem_data = mem_wr_q ? wdata_q : {DWIDTH{1'bz}};

    assign mem_wr   = mem_wr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign r0_ack   = ack0_q;
    assign r1_ack   = ack1_q;
    assign r0_rdata = rdata0_q;
    assign r1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized/directed bench for mem_arbiter with a
// transaction-level reference model (grant rule, memory image, rdata).
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_req = 0, r0_wr = 0, r1_req = 0, r1_wr = 0;
    logic [4:0] r0_addr = 0, r1_addr = 0;
    logic [7:0] r0_wdata = 0, r1_wdata = 0;
    logic       r0_ack, r1_ack, mem_wr, mem_rd;
    logic [7:0] r0_rdata, r1_rdata;
    logic [4:0] mem_addr;
    wire  [7:0] mem_data;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory device: asynchronous read onto the bus, write on the rising edge.
    logic [7:0] mem [32];
    bit         mem_rdy = 1'b0;
    assign mem_data = mem_rd ? mem[mem_addr] : 8'bz;
    always @(posedge clk) begin
        if (!mem_rdy) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            mem_rdy <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_data;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int ecnt = 0;
    always @(posedge clk) ecnt++;

    // Requester-side bookkeeping (written by drivers).
    int         req_seq [2] = '{0, 0};
    int         raise_e [2] = '{0, 0};
    bit         op_wr   [2];
    logic [4:0] op_a    [2];
    logic [7:0] op_d    [2];

    // Reference model state (written by the monitor only).
    int         ack_seq [2] = '{0, 0};
    int         m_last = 1;
    logic [7:0] ref_mem [32] = '{default: 8'h00};
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    logic [1:0] prev_ack = 2'b00;
    int         ack_order [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_last = 1;
            ack_seq[0] = req_seq[0];
            ack_seq[1] = req_seq[1];
            last_rd[0] = 8'h00;
            last_rd[1] = 8'h00;
            prev_ack = 2'b00;
        end else begin
            chk("wr_rd_excl", 32'(mem_wr & mem_rd), 32'd0);
            if (mem_rd) chk("rd_bus", 32'(mem_data), 32'(mem[mem_addr]));
            chk("ack_onehot", 32'(r0_ack & r1_ack), 32'd0);
            if (r0_ack ^ r1_ack) begin
                int w, e;
                bit c0, c1;
                logic [7:0] rd;
                w  = r1_ack ? 1 : 0;
                // A requester contends if it was pending at the grant edge,
                // one edge before the ack rose.
                c0 = (req_seq[0] != ack_seq[0]) && (raise_e[0] <= ecnt - 1);
                c1 = (req_seq[1] != ack_seq[1]) && (raise_e[1] <= ecnt - 1);
                e  = (c0 && c1) ? (m_last == 1 ? 0 : 1) : (c1 ? 1 : 0);
                chk("ack_contender", 32'(c0 | c1), 32'd1);
                chk("grant_winner", 32'(w), 32'(e));
                chk("ack_pulse", 32'(prev_ack[w]), 32'd0);
                m_last = w;
                ack_seq[w] = req_seq[w];
                rd = w ? r1_rdata : r0_rdata;
                if (op_wr[w]) begin
                    chk("rdata_hold", 32'(rd), 32'(last_rd[w]));
                    ref_mem[op_a[w]] = op_d[w];
                end else begin
                    chk("rdata", 32'(rd), 32'(ref_mem[op_a[w]]));
                    last_rd[w] = ref_mem[op_a[w]];
                end
                ack_order.push_back(w);
            end
            prev_ack = {r1_ack, r0_ack};
        end
    end

    // Issue one request (call at #1 after a rising edge); returns read data,
    // latency in negedges from raise to ack, and mem strobe counts seen.
    task automatic do_req(input int id, input bit wr, input logic [4:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int nwr, output int nrd);
        bit got;
        op_wr[id] = wr; op_a[id] = a; op_d[id] = d;
        raise_e[id] = ecnt + 1;
        req_seq[id]++;
        if (id == 0) begin r0_wr = wr; r0_addr = a; r0_wdata = d; r0_req = 1'b1; end
        else         begin r1_wr = wr; r1_addr = a; r1_wdata = d; r1_req = 1'b1; end
        got = 0; lat = 0; nwr = 0; nrd = 0; rd = 8'h00;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            nwr += int'(mem_wr);
            nrd += int'(mem_rd);
            if ((id == 0) ? r0_ack : r1_ack) begin
                got = 1;
                lat = k;
                rd = (id == 0) ? r0_rdata : r1_rdata;
            end
        end
        chk("ack_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        // Drop the request and scramble operands; they must not matter now.
        if (id == 0) begin r0_req = 1'b0; r0_wr = 1'($urandom); r0_addr = 5'($urandom); r0_wdata = 8'($urandom); end
        else         begin r1_req = 1'b0; r1_wr = 1'($urandom); r1_addr = 5'($urandom); r1_wdata = 8'($urandom); end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] rd;
        int lat, nw, nr;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_r0_ack", 32'(r0_ack), 32'd0);
        chk("rst_r1_ack", 32'(r1_ack), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_r0_rdata", 32'(r0_rdata), 32'd0);
        chk("rst_r1_rdata", 32'(r1_rdata), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write then read at the top address
        do_req(0, 1'b1, 5'h1F, 8'hA5, rd, lat, nw, nr);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_strobe_cycles", 32'(nw), 32'd1);
        chk("wr_no_rd", 32'(nr), 32'd0);
        do_req(0, 1'b0, 5'h1F, 8'h00, rd, lat, nw, nr);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_strobe_cycles", 32'(nr), 32'd1);
        chk("rd_data_a5", 32'(rd), 32'hA5);

        // Fill addresses 31..1 from requester 1 and read back
        for (int i = 0; i < 31; i++) do_req(1, 1'b1, 5'(31 - i), 8'(i), rd, lat, nw, nr);
        for (int i = 0; i < 31; i++) begin
            do_req(1, 1'b0, 5'(31 - i), 8'h00, rd, lat, nw, nr);
            chk("fill_rd", 32'(rd), 32'(i));
        end

        // Reset in the middle of a write: outputs clear at once, no ack follows
        r0_wr = 1'b1; r0_addr = 5'h02; r0_wdata = 8'h5A; r0_req = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_access", 32'(mem_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_wr", 32'(mem_wr), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_r0_rdata", 32'(r0_rdata), 32'd0);
        chk("abort_r1_rdata", 32'(r1_rdata), 32'd0);
        r0_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_ack", 32'(r0_ack | r1_ack), 32'd0);
        end
        @(posedge clk); #1;

        // Contention from reset: r0 first, r1 three cycles later
        ack_order.delete();
        fork
            begin
                logic [7:0] rv; int l, a, b;
                do_req(0, 1'b1, 5'h03, 8'h11, rv, l, a, b);
                chk("cont_r0_lat", 32'(l), 32'd3);
            end
            begin
                logic [7:0] rv; int l, a, b;
                do_req(1, 1'b1, 5'h04, 8'h22, rv, l, a, b);
                chk("cont_r1_lat", 32'(l), 32'd6);
            end
        join
        chk("cont_n_acks", 32'(ack_order.size()), 32'd2);
        if (ack_order.size() == 2) begin
            chk("cont_first", 32'(ack_order[0]), 32'd0);
            chk("cont_second", 32'(ack_order[1]), 32'd1);
        end
        do_req(0, 1'b0, 5'h03, 8'h00, rd, lat, nw, nr);
        chk("cont_rd_11", 32'(rd), 32'h11);
        do_req(1, 1'b0, 5'h04, 8'h00, rd, lat, nw, nr);
        chk("cont_rd_22", 32'(rd), 32'h22);

        // Fairness: four back-to-back reads from each side
        do_reset();
        ack_order.delete();
        fork
            begin
                logic [7:0] rv; int l, a, b;
                for (int i = 0; i < 4; i++) do_req(0, 1'b0, 5'($urandom), 8'h00, rv, l, a, b);
            end
            begin
                logic [7:0] rv; int l, a, b;
                for (int i = 0; i < 4; i++) do_req(1, 1'b0, 5'($urandom), 8'h00, rv, l, a, b);
            end
        join
        chk("fair_n_acks", 32'(ack_order.size()), 32'd8);
        for (int i = 0; i < ack_order.size() && i < 8; i++)
            chk("fair_order", 32'(ack_order[i]), 32'(i % 2));

        // Random mixed traffic over a small address window
        fork
            begin
                logic [7:0] rv; int l, a, b;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    do_req(0, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom), rv, l, a, b);
                end
            end
            begin
                logic [7:0] rv; int l, a, b;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    do_req(1, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom), rv, l, a, b);
                end
            end
        join

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
